// File: rtl/riscv_mem_lsu_pkg.sv
// Shared LSU definitions: data width, func3 and src_rd encodings, FSM states,
// and the store lane-replication helper.
package riscv_mem_lsu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] SRC_RD_ALU  = 2'b00;
   localparam logic [1:0] SRC_RD_LOAD = 2'b01;
   localparam logic [1:0] SRC_RD_PC4  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // Replicate the store operand across all lanes so any byte enable finds its data.
   function automatic logic [XLEN-1:0] store_replicate(input logic [2:0]      func3,
                                                       input logic [XLEN-1:0] wd);
      logic [XLEN-1:0] res;
      case (func3)
         F3_SB:   res = {(XLEN/8){wd[7:0]}};
         F3_SH:   res = {(XLEN/16){wd[15:0]}};
         default: res = wd;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/riscv_mem_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory/interconnect (slave).
interface riscv_mem_lsu_if;
   import riscv_mem_lsu_pkg::*;

   logic            o_lsu_dmem_req;
   logic            o_lsu_dmem_we;
   logic [XLEN-1:0] o_lsu_dmem_addr;
   logic [XLEN-1:0] o_lsu_dmem_wdata;
   logic [3:0]      o_lsu_dmem_be;
   logic            i_lsu_dmem_gnt;
   logic            i_lsu_dmem_rvalid;
   logic [XLEN-1:0] i_lsu_dmem_rdata;

   modport master (
      output o_lsu_dmem_req, o_lsu_dmem_we, o_lsu_dmem_addr, o_lsu_dmem_wdata, o_lsu_dmem_be,
      input  i_lsu_dmem_gnt, i_lsu_dmem_rvalid, i_lsu_dmem_rdata
   );

   modport slave (
      input  o_lsu_dmem_req, o_lsu_dmem_we, o_lsu_dmem_addr, o_lsu_dmem_wdata, o_lsu_dmem_be,
      output i_lsu_dmem_gnt, i_lsu_dmem_rvalid, i_lsu_dmem_rdata
   );

endinterface

// File: rtl/riscv_lsu_load_align.sv
// Combinational load path: shift the bus word down to the addressed lane,
// then sign- or zero-extend according to func3.
module riscv_lsu_load_align
   import riscv_mem_lsu_pkg::*;
(
   input  logic [XLEN-1:0] i_rdata,
   input  logic [1:0]      i_offset,
   input  logic [2:0]      i_func3,
   output logic [XLEN-1:0] o_data
);

   logic [XLEN-1:0] shifted;

   assign shifted = i_rdata >> {i_offset, 3'b000};

   always_comb begin
      o_data = '0;
      case (i_func3)
         F3_LB:   o_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_LH:   o_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_LW:   o_data = shifted;
         F3_LBU:  o_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_LHU:  o_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/riscv_mem_lsu.sv
// MEM-stage load/store unit: IDLE/REQ/WAIT/DONE handshake FSM with timeout.
// Define RISCV_LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module riscv_mem_lsu
   import riscv_mem_lsu_pkg::*;
#(
   parameter int   TIMEOUT_CYCLES = 16,
   parameter logic REGISTER_INIT  = 1'b0
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic [1:0]      i_lsu_src_rd,
   input  logic            i_lsu_mem_wr_en,
   input  logic [3:0]      i_lsu_mem_byte_sel,
   input  logic [XLEN-1:0] i_lsu_alu_result,
   input  logic [XLEN-1:0] i_lsu_write_data,
   input  logic [2:0]      i_lsu_func3,
   riscv_mem_lsu_if.master dmem,
   output logic            o_lsu_stall,
   output logic [XLEN-1:0] o_lsu_rd_data,
   output logic            o_lsu_done,
   output logic            o_lsu_err,
   output logic            o_lsu_misalign
);

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   lsu_state_e      state_reg;
   logic [15:0]     cnt_reg;
   logic [1:0]      off_reg;
   logic [2:0]      func3_reg;
   logic            is_load_reg;
   logic            req_reg;
   logic            we_reg;
   logic [XLEN-1:0] addr_reg;
   logic [XLEN-1:0] wdata_reg;
   logic [3:0]      be_reg;
   logic [XLEN-1:0] rd_data_reg;
   logic            done_reg;
   logic            err_reg;

   logic            access;
   logic            misaligned;
   logic            timeout;
   logic [15:0]     cnt_next;
   logic [3:0]      be_next;
   logic [XLEN-1:0] load_data;

   assign access   = (i_lsu_src_rd == SRC_RD_LOAD) || i_lsu_mem_wr_en;
   assign cnt_next = cnt_reg + 16'd1;
   assign timeout  = (cnt_next >= TIMEOUT_LIMIT);
   assign be_next  = i_lsu_mem_byte_sel << i_lsu_alu_result[1:0];

   // Stall must rise in the very cycle the access appears, before the FSM leaves IDLE.
   assign o_lsu_stall = (state_reg == ST_REQ) || (state_reg == ST_WAIT) ||
                        ((state_reg == ST_IDLE) && access);

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
   logic misalign_reg;

   assign misaligned = ((i_lsu_mem_byte_sel == 4'b0011) && i_lsu_alu_result[0]) ||
                       ((i_lsu_mem_byte_sel == 4'b1111) && (i_lsu_alu_result[1:0] != 2'b00));

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) misalign_reg <= REGISTER_INIT;
      else         misalign_reg <= (state_reg == ST_IDLE) && access && misaligned;
   end

   assign o_lsu_misalign = misalign_reg;
`else
   assign misaligned     = 1'b0;
   assign o_lsu_misalign = 1'b0;
`endif

   riscv_lsu_load_align u_load_align (
      .i_rdata  (dmem.i_lsu_dmem_rdata),
      .i_offset (off_reg),
      .i_func3  (func3_reg),
      .o_data   (load_data)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         off_reg     <= '0;
         func3_reg   <= '0;
         is_load_reg <= 1'b0;
         // The bus request must never be left asserted by reset, whatever REGISTER_INIT is.
         req_reg     <= 1'b0;
         we_reg      <= 1'b0;
         addr_reg    <= {XLEN{REGISTER_INIT}};
         wdata_reg   <= {XLEN{REGISTER_INIT}};
         be_reg      <= {4{REGISTER_INIT}};
         rd_data_reg <= {XLEN{REGISTER_INIT}};
         done_reg    <= REGISTER_INIT;
         err_reg     <= REGISTER_INIT;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (access) begin
                  off_reg     <= i_lsu_alu_result[1:0];
                  func3_reg   <= i_lsu_func3;
                  is_load_reg <= !i_lsu_mem_wr_en;
                  if (misaligned) begin
                     rd_data_reg <= '0;
                     done_reg    <= 1'b1;
                     state_reg   <= ST_DONE;
                  end else begin
                     req_reg   <= 1'b1;
                     we_reg    <= i_lsu_mem_wr_en;
                     addr_reg  <= {i_lsu_alu_result[XLEN-1:2], 2'b00};
                     wdata_reg <= store_replicate(i_lsu_func3, i_lsu_write_data);
                     be_reg    <= be_next;
                     cnt_reg   <= '0;
                     state_reg <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               cnt_reg <= cnt_next;
               if (dmem.i_lsu_dmem_gnt) begin
                  req_reg <= 1'b0;
                  we_reg  <= 1'b0;
                  if (is_load_reg) begin
                     state_reg <= ST_WAIT;
                  end else begin
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
                  end
               end else if (timeout) begin
                  req_reg     <= 1'b0;
                  we_reg      <= 1'b0;
                  rd_data_reg <= '0;
                  err_reg     <= 1'b1;
                  done_reg    <= 1'b1;
                  state_reg   <= ST_DONE;
               end
            end
            ST_WAIT: begin
               cnt_reg <= cnt_next;
               if (dmem.i_lsu_dmem_rvalid) begin
                  rd_data_reg <= load_data;
                  done_reg    <= 1'b1;
                  state_reg   <= ST_DONE;
               end else if (timeout) begin
                  rd_data_reg <= '0;
                  err_reg     <= 1'b1;
                  done_reg    <= 1'b1;
                  state_reg   <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign dmem.o_lsu_dmem_req   = req_reg;
   assign dmem.o_lsu_dmem_we    = we_reg;
   assign dmem.o_lsu_dmem_addr  = addr_reg;
   assign dmem.o_lsu_dmem_wdata = wdata_reg;
   assign dmem.o_lsu_dmem_be    = be_reg;
   assign o_lsu_rd_data         = rd_data_reg;
   assign o_lsu_done            = done_reg;
   assign o_lsu_err             = err_reg;

endmodule
